// File: rtl/dsp_mac_stream.sv
// dsp_mac_stream: three-stage stream-handshaked multiply-accumulate slice.
// S1 registers the operands and the pre-adder result. S2 registers the
// signed product. S3 accumulates over a frame delimited by s_last and emits
// one result per frame.
// Optional feature: define DSP_SAT_EN to clamp overflowing sums instead of
// letting them wrap. The sticky overflow flag is reported in both builds.
module dsp_mac_stream #(
   parameter int AW   = 18,
   parameter int BW   = 18,
   parameter int CW   = 48,
   parameter int PW   = 48,
   parameter int CNTW = 8
) (
   input  logic                   clk,
   input  logic                   RST,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic signed [AW-1:0]   s_A,
   input  logic signed [BW-1:0]   s_B,
   input  logic signed [BW-1:0]   s_D,
   input  logic signed [CW-1:0]   s_C,
   input  logic        [2:0]      s_MODE,
   input  logic                   s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic signed [PW-1:0]   m_P,
   output logic                   m_OVF,
   output logic        [CNTW-1:0] m_CNT
);

   localparam int MW = AW + BW + 1;

   // A result waiting for a consumer freezes the whole pipeline.
   logic stall;
   assign stall   = m_valid && !m_ready;
   assign s_ready = !stall;

   // ---------------- Stage S1: operands and pre-adder ----------------
   logic signed [BW:0]   d_ext, b_ext, pre_w;
   logic                 v1, sub1, last1;
   logic signed [AW-1:0] a1;
   logic signed [BW:0]   pre1;
   logic signed [CW-1:0] c1;

   assign d_ext = (BW+1)'(s_D);
   assign b_ext = (BW+1)'(s_B);

   // Pre-adder: D+B, D-B, or B passed through, one bit wider so it cannot overflow.
   always_comb begin
      // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
      pre_w = b_ext;
      if (s_MODE[0]) pre_w = s_MODE[1] ? (d_ext - b_ext) : (d_ext + b_ext);
   end

   // S1 capture: the valid bit follows s_valid whenever the pipe advances.
   always_ff @(posedge clk or posedge RST) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST) begin
         v1    <= 1'b0;
         a1    <= '0;
         pre1  <= '0;
         sub1  <= 1'b0;
         last1 <= 1'b0;
         c1    <= '0;
      end else if (!stall) begin
         v1 <= s_valid;
         if (s_valid) begin
            a1    <= s_A;
            pre1  <= pre_w;
            sub1  <= s_MODE[2];
            last1 <= s_last;
            c1    <= s_C;
         end
      end
   end

   // ---------------- Stage S2: signed multiply ----------------
   logic signed [MW-1:0] prod_w, prod2;
   logic                 v2, sub2, last2;
   logic signed [CW-1:0] c2;

   assign prod_w = MW'(a1) * MW'(pre1);

   // S2 capture of the product with the controls that travel alongside it.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         v2    <= 1'b0;
         prod2 <= '0;
         sub2  <= 1'b0;
         last2 <= 1'b0;
         c2    <= '0;
      end else if (!stall) begin
         v2 <= v1;
         if (v1) begin
            prod2 <= prod_w;
            sub2  <= sub1;
            last2 <= last1;
            c2    <= c1;
         end
      end
   end

   // ---------------- Stage S3: accumulate ----------------
   logic signed [PW-1:0] acc, base, prod_ext, sum, acc_next;
   logic [CNTW-1:0]      cnt, cnt_next;
   logic                 first, sticky, ovf, sticky_next;

   assign prod_ext = PW'(prod2);
   assign base     = first ? PW'(c2) : acc;
   assign sum      = sub2 ? (base - prod_ext) : (base + prod_ext);

   // Signed overflow: for an add the operand signs match, for a subtract they
   // differ, and in both cases the result sign departs from the base sign.
   assign ovf = ((base[PW-1] == prod_ext[PW-1]) != sub2) && (sum[PW-1] != base[PW-1]);

   // Next accumulator value, wrapped or clamped toward the sign of the true sum.
   always_comb begin
      acc_next = sum;
`ifdef DSP_SAT_EN
      if (ovf) acc_next = base[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
`endif
   end

   assign sticky_next = (first ? 1'b0 : sticky) | ovf;
   assign cnt_next    = first ? CNTW'(1) : ((cnt == '1) ? cnt : cnt + 1'b1);

   // Frame accumulation and result register; a last beat restarts the frame on the same edge.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         acc     <= '0;
         cnt     <= '0;
         sticky  <= 1'b0;
         first   <= 1'b1;
         m_valid <= 1'b0;
         m_P     <= '0;
         m_OVF   <= 1'b0;
         m_CNT   <= '0;
      end else if (!stall) begin
         m_valid <= v2 && last2;
         if (v2) begin
            if (last2) begin
               m_P    <= acc_next;
               m_OVF  <= sticky_next;
               m_CNT  <= cnt_next;
               acc    <= '0;
               cnt    <= '0;
               sticky <= 1'b0;
               first  <= 1'b1;
            end else begin
               acc    <= acc_next;
               cnt    <= cnt_next;
               sticky <= sticky_next;
               first  <= 1'b0;
            end
         end
      end
   end

endmodule
